control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Instruction decoder for the RV32I single-cycle core. Maps opcode/funct3/funct7 plus ALU
//  flags (zero, comparison) to datapath controls: PC select, writeback select, memory
//  strobes, immediate format, ALU op. Decode is purely combinational; clk/rst only gate
//  outputs to a safe NOP during reset.
// PARAMETERS
//  none (all encodings fixed, held in shared package)
// PORTS
//  clk         in   1  system clock (single clock domain)
//  rst         in   1  reset, synchronous, active-high
//  opcode      in   7  instr[6:0]
//  funct3      in   3  instr[14:12]
//  funct7      in   7  instr[31:25]; only bit 5 is decoded
//  zero        in   1  ALU result == 0
//  comparison  in   1  ALU less-than flag (signed or unsigned per ALUControl)
//  PCSrc       out  1  1 = take branch/jump target
//  Jump        out  1  1 for jal/jalr
//  ResultSrc   out  2  00 ALU, 01 data memory, 10 PC+4, 11 ImmExt
//  MemWrite    out  1  store strobe
//  MemRead     out  1  load strobe
//  ALUSrc      out  1  0 = rs2, 1 = ImmExt
//  ImmSrc      out  3  000 I, 001 S, 010 B, 011 J, 100 U
//  RegWrite    out  1  register file write enable
//  ALUControl  out  4  0000 ADD,0001 SUB,0010 AND,0011 OR,0100 XOR,0101 SLL,0110 SRL,
//                      0111 SRA,1000 SLT,1001 SLTU
// BEHAVIOUR
//  - Zero-cycle latency: outputs follow inputs combinationally.
//  - rst_q <= rst at each posedge clk; while rst_q=1 every output is 0 (NOP, ALU ADD).
//  - Main decode (RegWrite,ImmSrc,ALUSrc,MemWrite,MemRead,ResultSrc,Jump):
//    R   0110011: 1,000,0,0,0,00,0     I-ALU 0010011: 1,000,1,0,0,00,0
//    LD  0000011: 1,000,1,0,1,01,0     ST    0100011: 0,001,1,1,0,00,0
//    BR  1100011: 0,010,0,0,0,00,0     JAL   1101111: 1,011,0,0,0,10,1
//    JALR 1100111: 1,000,1,0,0,10,1    LUI   0110111: 1,100,0,0,0,11,0
//    any other opcode: all outputs 0 (ALUControl ADD).
//  - ALU decode: LD/ST/JAL/JALR/LUI -> ADD. R/I by funct3: 000 ADD (R with funct7[5]=1 ->
//    SUB; I always ADD), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (funct7[5]=1 -> SRA,
//    R and I), 110 OR, 111 AND. funct7 bits other than [5] ignored (funct7=0000001 -> base op).
//  - Branch: funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> SUB.
//  - PCSrc = Jump | (BR & taken); taken: beq zero, bne ~zero, blt/bltu comparison,
//    bge/bgeu ~comparison, funct3 010/011 never taken. PCSrc=0 for non-branch/jump.
//  - jalr target selection (ALU result vs PC+imm) is done in the datapath from opcode.
//  - funct3/funct7 X on opcodes that ignore them (LUI, JAL) must not affect outputs.
// STRUCTURE
//  - Shared package: opcode localparams, ALUControl, ImmSrc, ResultSrc enums.
//  - One sub-module: aludeco (opcode class, funct3, funct7[5] -> ALUControl). Main decode
//    and branch resolution stay inline; reset flag is the only flop.
// TESTING (rst high 2 cycles, then low; check after each input change)
//  - R op=0110011 f3=000 f7=0000001 -> RegWrite=1 ALUSrc=0 ResultSrc=00 ALUControl=0000 PCSrc=0
//  - I op=0010011 f3=000 f7=0110011 -> RegWrite=1 ALUSrc=1 ImmSrc=000 ALUControl=0000
//  - lw op=0000011 f3=010 -> MemRead=1 ResultSrc=01 ALUSrc=1 RegWrite=1; sw op=0100011 ->
//    MemWrite=1 ImmSrc=001 RegWrite=0 MemRead=0
//  - lui op=0110111 f3=X -> ImmSrc=100 ResultSrc=11 RegWrite=1 no X on any output
//  - bge op=1100011 f3=101 comparison=1 -> PCSrc=0 ALUControl=1000 ImmSrc=010; comparison=0
//    -> PCSrc=1; beq zero=1 -> PCSrc=1
//  - rst=1 mid-R-type -> after next posedge all outputs 0; rst=0 -> decode resumes next edge

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared encodings for the RV32I control unit: opcodes, ALU/immediate/result selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_unit_pkg;

   // Base opcodes decoded by the core
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_SLT  = 4'b1000,
      ALU_SLTU = 4'b1001
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_src_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

   // Opcode class handed to the ALU decoder; anything that only needs an adder is ADD
   typedef enum logic [1:0] {
      ALUOP_ADD = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_R   = 2'b10,
      ALUOP_I   = 2'b11
   } alu_op_e;

   // Branch condition from funct3 and the ALU flags; 010/011 are not branches and never take
   function automatic logic br_taken(input logic [2:0] f3, input logic zero, input logic cmp);
      logic t;
      t = 1'b0;
      case (f3)
         3'b000:  t = zero;
         3'b001:  t = ~zero;
         3'b100,
         3'b110:  t = cmp;
         3'b101,
         3'b111:  t = ~cmp;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/control_unit_aludeco.sv
// ALU operation decoder: opcode class + funct3 + funct7[5] -> ALUControl.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output always valid for the current inputs.
module control_unit_aludeco
   import control_unit_pkg::*;
(
   input  alu_op_e     alu_op,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   output alu_ctrl_e   alu_ctrl
);

   // funct3 is only looked at for branch and R/I classes, so X on LUI/JAL stays contained
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         ALUOP_BR: begin
            case (funct3)
               3'b100, 3'b101: alu_ctrl = ALU_SLT;
               3'b110, 3'b111: alu_ctrl = ALU_SLTU;
               default:        alu_ctrl = ALU_SUB;
            endcase
         end
         ALUOP_R, ALUOP_I: begin
            case (funct3)
               // only register-register forms have a SUB; addi ignores funct7
               3'b000:  alu_ctrl = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001:  alu_ctrl = ALU_SLL;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b011:  alu_ctrl = ALU_SLTU;
               3'b100:  alu_ctrl = ALU_XOR;
               3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110:  alu_ctrl = ALU_OR;
               default: alu_ctrl = ALU_AND;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// RV32I single-cycle decoder: instruction fields + ALU flags -> datapath controls.
// Latency: zero cycles; a registered copy of rst forces a NOP on all outputs.
// Backpressure: none; outputs always reflect the current instruction.
module control_unit
   import control_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic        zero,
   input  logic        comparison,
   output logic        PCSrc,
   output logic        Jump,
   output logic [1:0]  ResultSrc,
   output logic        MemWrite,
   output logic        MemRead,
   output logic        ALUSrc,
   output logic [2:0]  ImmSrc,
   output logic        RegWrite,
   output logic [3:0]  ALUControl
);

   logic        rst_d, rst_q;

   logic        dec_reg_write;
   imm_src_e    dec_imm_src;
   logic        dec_alu_src;
   logic        dec_mem_write;
   logic        dec_mem_read;
   result_src_e dec_result_src;
   logic        dec_jump;
   logic        dec_branch;
   alu_op_e     dec_alu_op;
   alu_ctrl_e   dec_alu_ctrl;
   logic        dec_pc_src;

   // Only funct7[5] distinguishes RV32I ops; the rest is deliberately ignored
   logic        unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   // Next value of the reset flag
   always_comb begin
      rst_d = rst;
   end

   // Reset flag register, the only state in the block
   always_ff @(posedge clk) begin
      rst_q <= rst_d;
   end

   // Main decode: opcode -> datapath controls; unknown opcodes decode as a NOP
   always_comb begin
      dec_reg_write  = 1'b0;
      dec_imm_src    = IMM_I;
      dec_alu_src    = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_read   = 1'b0;
      dec_result_src = RES_ALU;
      dec_jump       = 1'b0;
      dec_branch     = 1'b0;
      dec_alu_op     = ALUOP_ADD;
      case (opcode)
         OP_R: begin
            dec_reg_write = 1'b1;
            dec_alu_op    = ALUOP_R;
         end
         OP_I: begin
            dec_reg_write = 1'b1;
            dec_alu_src   = 1'b1;
            dec_alu_op    = ALUOP_I;
         end
         OP_LD: begin
            dec_reg_write  = 1'b1;
            dec_alu_src    = 1'b1;
            dec_mem_read   = 1'b1;
            dec_result_src = RES_MEM;
         end
         OP_ST: begin
            dec_imm_src   = IMM_S;
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
         end
         OP_BR: begin
            dec_imm_src = IMM_B;
            dec_branch  = 1'b1;
            dec_alu_op  = ALUOP_BR;
         end
         OP_JAL: begin
            dec_reg_write  = 1'b1;
            dec_imm_src    = IMM_J;
            dec_result_src = RES_PC4;
            dec_jump       = 1'b1;
         end
         OP_JALR: begin
            dec_reg_write  = 1'b1;
            dec_alu_src    = 1'b1;
            dec_result_src = RES_PC4;
            dec_jump       = 1'b1;
         end
         OP_LUI: begin
            dec_reg_write  = 1'b1;
            dec_imm_src    = IMM_U;
            dec_result_src = RES_IMM;
         end
         default: ;
      endcase
   end

   control_unit_aludeco u_aludeco (
      .alu_op   (dec_alu_op),
      .funct3   (funct3),
      .funct7_5 (funct7[5]),
      .alu_ctrl (dec_alu_ctrl)
   );

   // Branch resolution; the branch term is gated first so funct3 cannot leak into jumps/NOPs
   always_comb begin
      dec_pc_src = dec_jump;
      if (dec_branch) begin
         dec_pc_src = br_taken(funct3, zero, comparison);
      end
   end

   // Output stage: everything forced to NOP/ADD while the registered reset is high
   always_comb begin
      PCSrc      = 1'b0;
      Jump       = 1'b0;
      ResultSrc  = RES_ALU;
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      ALUSrc     = 1'b0;
      ImmSrc     = IMM_I;
      RegWrite   = 1'b0;
      ALUControl = ALU_ADD;
      if (!rst_q) begin
         PCSrc      = dec_pc_src;
         Jump       = dec_jump;
         ResultSrc  = dec_result_src;
         MemWrite   = dec_mem_write;
         MemRead    = dec_mem_read;
         ALUSrc     = dec_alu_src;
         ImmSrc     = dec_imm_src;
         RegWrite   = dec_reg_write;
         ALUControl = dec_alu_ctrl;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode table, branch resolution, reset gating.
// Latency: checks 1 time unit after each input change or clock edge.
// Backpressure: n/a.
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        zero;
   logic        comparison;
   logic        PCSrc;
   logic        Jump;
   logic [1:0]  ResultSrc;
   logic        MemWrite;
   logic        MemRead;
   logic        ALUSrc;
   logic [2:0]  ImmSrc;
   logic        RegWrite;
   logic [3:0]  ALUControl;

   int checks   = 0;
   int failures = 0;

   control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7     (funct7),
      .zero       (zero),
      .comparison (comparison),
      .PCSrc      (PCSrc),
      .Jump       (Jump),
      .ResultSrc  (ResultSrc),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .ALUSrc     (ALUSrc),
      .ImmSrc     (ImmSrc),
      .RegWrite   (RegWrite),
      .ALUControl (ALUControl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output bundle: {PCSrc,Jump,ResultSrc,MemWrite,MemRead,ALUSrc,ImmSrc,RegWrite,ALUControl}
   logic [14:0] obs;
   assign obs = {PCSrc, Jump, ResultSrc, MemWrite, MemRead, ALUSrc, ImmSrc, RegWrite, ALUControl};

   function automatic logic [14:0] mk(input logic pc, input logic j, input logic [1:0] rs,
                                      input logic mw, input logic mr, input logic as,
                                      input logic [2:0] imm, input logic rw, input logic [3:0] alu);
      return {pc, j, rs, mw, mr, as, imm, rw, alu};
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input logic c);
      opcode     = op;
      funct3     = f3;
      funct7     = f7;
      zero       = z;
      comparison = c;
   endtask

   task automatic vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic z, input logic c, input logic [14:0] exp);
      drive(op, f3, f7, z, c);
      #1;
      chk(tag, {17'd0, obs}, {17'd0, exp});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(7'b0110011, 3'b000, 7'b0000001, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_nop", {17'd0, obs}, 32'd0);
      rst = 1'b0;
      #1;
      chk("reset_release_hold", {17'd0, obs}, 32'd0);
      @(posedge clk);
      #1;
      chk("reset_release_decode", {17'd0, obs}, {17'd0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0000)});

      // R-type
      vec("r_add_f7lsb", 7'b0110011, 3'b000, 7'b0000001, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0000));
      vec("r_sub",       7'b0110011, 3'b000, 7'b0100000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0001));
      vec("r_sra",       7'b0110011, 3'b101, 7'b0100000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0111));
      vec("r_srl",       7'b0110011, 3'b101, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0110));
      vec("r_sltu",      7'b0110011, 3'b011, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b1001));
      vec("r_and",       7'b0110011, 3'b111, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0010));
      // I-type ALU
      vec("i_addi_f7",   7'b0010011, 3'b000, 7'b0110011, 0, 0, mk(0,0,2'b00,0,0,1,3'b000,1,4'b0000));
      vec("i_srai",      7'b0010011, 3'b101, 7'b0100000, 0, 0, mk(0,0,2'b00,0,0,1,3'b000,1,4'b0111));
      vec("i_slli",      7'b0010011, 3'b001, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,1,3'b000,1,4'b0101));
      vec("i_slti",      7'b0010011, 3'b010, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,1,3'b000,1,4'b1000));
      vec("i_xori",      7'b0010011, 3'b100, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,1,3'b000,1,4'b0100));
      vec("i_ori",       7'b0010011, 3'b110, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,1,3'b000,1,4'b0011));
      // memory
      vec("lw",          7'b0000011, 3'b010, 7'b0000000, 0, 0, mk(0,0,2'b01,0,1,1,3'b000,1,4'b0000));
      vec("sw",          7'b0100011, 3'b010, 7'b0100000, 0, 0, mk(0,0,2'b00,1,0,1,3'b001,0,4'b0000));
      // LUI with junk / unknown function fields
      vec("lui_junk",    7'b0110111, 3'b101, 7'b0100000, 1, 1, mk(0,0,2'b11,0,0,0,3'b100,1,4'b0000));
      vec("lui_x",       7'b0110111, 3'bxxx, 7'bxxxxxxx, 0, 0, mk(0,0,2'b11,0,0,0,3'b100,1,4'b0000));
      // branches
      vec("bge_cmp1",    7'b1100011, 3'b101, 7'b0000000, 0, 1, mk(0,0,2'b00,0,0,0,3'b010,0,4'b1000));
      vec("bge_cmp0",    7'b1100011, 3'b101, 7'b0000000, 0, 0, mk(1,0,2'b00,0,0,0,3'b010,0,4'b1000));
      vec("beq_z1",      7'b1100011, 3'b000, 7'b0000000, 1, 0, mk(1,0,2'b00,0,0,0,3'b010,0,4'b0001));
      vec("beq_z0",      7'b1100011, 3'b000, 7'b0000000, 0, 1, mk(0,0,2'b00,0,0,0,3'b010,0,4'b0001));
      vec("bne_z0",      7'b1100011, 3'b001, 7'b0000000, 0, 0, mk(1,0,2'b00,0,0,0,3'b010,0,4'b0001));
      vec("blt_cmp1",    7'b1100011, 3'b100, 7'b0000000, 0, 1, mk(1,0,2'b00,0,0,0,3'b010,0,4'b1000));
      vec("bltu_cmp1",   7'b1100011, 3'b110, 7'b0000000, 0, 1, mk(1,0,2'b00,0,0,0,3'b010,0,4'b1001));
      vec("bgeu_cmp1",   7'b1100011, 3'b111, 7'b0000000, 1, 1, mk(0,0,2'b00,0,0,0,3'b010,0,4'b1001));
      vec("br_f3_010",   7'b1100011, 3'b010, 7'b0000000, 1, 1, mk(0,0,2'b00,0,0,0,3'b010,0,4'b0001));
      vec("br_f3_011",   7'b1100011, 3'b011, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,0,3'b010,0,4'b0001));
      // jumps
      vec("jal_junk",    7'b1101111, 3'b001, 7'b0100000, 1, 0, mk(1,1,2'b10,0,0,0,3'b011,1,4'b0000));
      vec("jalr",        7'b1100111, 3'b000, 7'b0000000, 0, 0, mk(1,1,2'b10,0,0,1,3'b000,1,4'b0000));
      // unknown opcodes
      vec("illegal_ff",  7'b1111111, 3'b000, 7'b0100000, 1, 1, mk(0,0,2'b00,0,0,0,3'b000,0,4'b0000));
      vec("illegal_00",  7'b0000000, 3'b101, 7'b0000000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,0,4'b0000));

      // reset asserted mid R-type: takes effect at the next edge, releases one edge after
      vec("mid_r_sub",   7'b0110011, 3'b000, 7'b0100000, 0, 0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0001));
      rst = 1'b1;
      #1;
      chk("mid_rst_pre_edge", {17'd0, obs}, {17'd0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0001)});
      @(posedge clk);
      #1;
      chk("mid_rst_nop", {17'd0, obs}, 32'd0);
      rst = 1'b0;
      #1;
      chk("mid_rst_hold", {17'd0, obs}, 32'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_resume", {17'd0, obs}, {17'd0, mk(0,0,2'b00,0,0,0,3'b000,1,4'b0001)});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
